// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, reads the combinational IM and
// queues {pc, instr} pairs toward the F/D register through a small FIFO.
module fetch_ctrl #(
  parameter logic [31:0] PC_INIT   = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  input  logic        fd_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        addr_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  // One bit wider than the PC so a window ending at 2^32 still compares correctly.
  localparam logic [32:0]      PC_END = {1'b0, PC_INIT} + 33'(4 * IM_WORDS);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [31:0]      fpc;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic             bad, pop, push;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    bad     = (fpc[1:0] != 2'b00) || (fpc < PC_INIT) || ({1'b0, fpc} >= PC_END);
    pop     = fd_valid && fd_ready;
    push    = (state == RUN) && !bad && !redirect && ((count != FULL) || pop);
    state_n = state;
    if (redirect) begin
      state_n = RUN;
    end else if ((state == RUN) && bad) begin
      state_n = HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc   <= PC_INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: the buffer storage is reset because the head entry drives
      // fd_pc/fd_instr directly and those must read zero after reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect) begin
      // Flush wins over any same-cycle pop or push.
      fpc   <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        buf_pc[tail]    <= fpc;
        buf_instr[tail] <= im_instr;
        tail            <= tail + PTR_W'(1);
        fpc             <= fpc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs depend only on registers; fd_ready reaches nothing but enables.
  assign im_addr  = fpc;
  assign fd_valid = (count != '0);
  assign fd_pc    = buf_pc[head];
  assign fd_instr = buf_instr[head];
  assign addr_err = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table for streaming and
// backpressure, then hand sequences for redirect, halt, misalign and reset.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fd_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        addr_err;

  logic [31:0] im [4096];
  logic [31:0] im_off;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        chk_head;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eim;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_instr    (im_instr),
    .fd_valid    (fd_valid),
    .fd_instr    (fd_instr),
    .fd_pc       (fd_pc),
    .fd_ready    (fd_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational IM covering 0x3000..0x6FFC.
  always_comb begin
    im_off   = im_addr - 32'h3000;
    im_instr = 32'hdead_beef;
    if ((im_addr[1:0] == 2'b00) && (im_addr >= 32'h3000) && (im_addr < 32'h7000)) begin
      im_instr = im[im_off[13:2]];
    end
  end

  function automatic logic [31:0] im_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h3000;
    return im[off[13:2]];
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rpc,
                              input logic rdy, input logic chk, input logic chk_head,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                              input logic [31:0] eim, input logic eerr);
    vec_t v;
    v.rst = rst;  v.rdr = rdr;  v.rpc = rpc;  v.rdy = rdy;
    v.chk = chk;  v.chk_head = chk_head;  v.ev = ev;
    v.epc = epc;  v.einstr = einstr;  v.eim = eim;  v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic step(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset       = rst;
    redirect    = rdr;
    redirect_pc = rpc;
    fd_ready    = rdy;
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ev, input logic [31:0] eim,
                              input logic eerr);
    check({tag, "_valid"}, 32'(fd_valid), 32'(ev));
    check({tag, "_im_addr"}, im_addr, eim);
    check({tag, "_addr_err"}, 32'(addr_err), 32'(eerr));
  endtask

  task automatic expect_head(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
    check({tag, "_fd_pc"}, fd_pc, epc);
    check({tag, "_fd_instr"}, fd_instr, einstr);
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    fd_ready    = 1'b0;

    for (int i = 0; i < 4096; i++) im[i] = 32'ha000_0000 | i;
    im[0] = 32'h3401ffff;  im[1] = 32'h34020010;  im[2] = 32'h00221821;
    im[3] = 32'hac030000;  im[4] = 32'h8c040000;  im[5] = 32'h10640001;
    im[6] = 32'h34050abc;  im[7] = 32'h00000000;  im[8] = 32'h34061234;

    // Streaming: one instruction per cycle from cycle 1.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h3000, 0));
    for (int c = 1; c <= 9; c++) begin
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h3000 + 4 * (c - 1),
                        im_word(32'h3000 + 4 * (c - 1)), 32'h3000 + 4 * c, 0));
    end
    // Backpressure: fills to two entries, im_addr parks at 0x3008, then drains in order.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h3000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h3000, im[0], 32'h3004, 0));
    for (int c = 2; c <= 4; c++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h3000, im[0], 32'h3008, 0));
    end
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h3000, im[0], 32'h3008, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h3004, im[1], 32'h300c, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h3008, im[2], 32'h3010, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h300c, im[3], 32'h3014, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
      if (vecs[i].chk) begin
        expect_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].eim, vecs[i].eerr);
      end
      if (vecs[i].chk_head) begin
        expect_head($sformatf("v%0d", i), vecs[i].epc, vecs[i].einstr);
      end
    end

    // Redirect while full with a same-cycle pop that must be ignored.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h3010, 1);
    expect_state("rf_full", 1, 32'h3008, 0);
    expect_head("rf_full", 32'h3000, im[0]);
    step(0, 0, 0, 1);
    expect_state("rf_bubble", 0, 32'h3010, 0);
    step(0, 0, 0, 1);
    expect_state("rf_first", 1, 32'h3014, 0);
    expect_head("rf_first", 32'h3010, im[4]);
    step(0, 0, 0, 0);
    expect_head("rf_second", 32'h3014, im[5]);
    step(0, 0, 0, 0);
    expect_state("rf_stall", 1, 32'h301c, 0);
    expect_head("rf_stall", 32'h3014, im[5]);
    step(0, 0, 0, 0);
    expect_state("rf_hold", 1, 32'h301c, 0);
    expect_head("rf_hold", 32'h3014, im[5]);

    // Run off the end of IM, drain in HALT, then recover by redirect.
    step(0, 1, 32'h6ffc, 0);
    step(0, 0, 0, 0);
    expect_state("end_bubble", 0, 32'h6ffc, 0);
    step(0, 0, 0, 0);
    expect_state("end_last", 1, 32'h7000, 0);
    expect_head("end_last", 32'h6ffc, im[4095]);
    step(0, 0, 0, 1);
    expect_state("end_halt", 1, 32'h7000, 1);
    expect_head("end_halt", 32'h6ffc, im[4095]);
    step(0, 0, 0, 1);
    expect_state("end_drained", 0, 32'h7000, 1);
    step(0, 1, 32'h3000, 1);
    expect_state("end_sticky", 0, 32'h7000, 1);
    step(0, 0, 0, 1);
    expect_state("end_clear", 0, 32'h3000, 0);
    step(0, 0, 0, 1);
    expect_state("end_resume", 1, 32'h3004, 0);
    expect_head("end_resume", 32'h3000, im[0]);

    // Misaligned redirect target halts one cycle after it is presented.
    step(0, 1, 32'h3002, 1);
    step(0, 0, 0, 1);
    expect_state("mis_present", 0, 32'h3002, 0);
    step(0, 0, 0, 1);
    expect_state("mis_halt", 0, 32'h3002, 1);
    step(0, 0, 0, 1);
    expect_state("mis_hold", 0, 32'h3002, 1);

    // Reset with a full buffer and a competing redirect.
    step(0, 1, 32'h3000, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_state("rst_full", 1, 32'h3008, 0);
    step(1, 1, 32'h3100, 0);
    step(0, 0, 0, 1);
    expect_state("rst_after", 0, 32'h3000, 0);
    expect_head("rst_after", 32'h0, 32'h0);
    step(0, 0, 0, 1);
    expect_state("rst_first", 1, 32'h3004, 0);
    expect_head("rst_first", 32'h3000, im[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
